uno_card_pile: RTL

//  Parametrised draw/discard pile engine for the UNO game controller. Holds every card in one

---
 rtl/uno_pkg.sv | 85 ++++++++
 rtl/uno_lfsr16.sv | 38 +++
 rtl/uno_card_pile.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uno_pkg.sv
// Package shared by the UNO card pile engine.
//   - colour_e / value_e / card_t : 6-bit card code {colour[1:0], value[3:0]}
//   - state_e                      : pile engine FSM states
//   - uno_card_at(idx)             : canonical (unshuffled) deck order, idx 0..107
//   - mask_upto_msb(x)             : all-ones mask covering x's most significant set bit
//   - LFSR_SEED / LFSR_TAPS        : default seed and Galois taps (16,14,13,11)
package uno_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2,
    BLUE   = 2'd3
  } colour_e;

  typedef enum logic [3:0] {
    V0 = 4'd0, V1 = 4'd1, V2 = 4'd2, V3 = 4'd3, V4 = 4'd4,
    V5 = 4'd5, V6 = 4'd6, V7 = 4'd7, V8 = 4'd8, V9 = 4'd9,
    SKIP  = 4'd10,
    REV   = 4'd11,
    DRAW2 = 4'd12,
    WILD  = 4'd13,
    WILD4 = 4'd14
  } value_e;

  typedef struct packed {
    colour_e colour;
    value_e  value;
  } card_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_DRAW,
    ST_RECYCLE,
    ST_SHUFFLE
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Deck layout: 25 cards per colour (one 0, two each of 1..9, SKIP, REV,
  // DRAW2) for idx 0..99, then one WILD per colour (100..103), then one
  // WILD4 per colour (104..107). Within a colour, slot j holds value (j+1)/2.
  function automatic card_t uno_card_at(input logic [6:0] idx);
    card_t      c;
    logic [6:0] base;
    logic [4:0] j;
    logic [1:0] col;
    c    = '{colour: RED, value: V0};
    base = 7'd0;
    col  = 2'd0;
    if (idx < 7'd100) begin
      if (idx >= 7'd75) begin
        col  = 2'd3;
        base = 7'd75;
      end else if (idx >= 7'd50) begin
        col  = 2'd2;
        base = 7'd50;
      end else if (idx >= 7'd25) begin
        col  = 2'd1;
        base = 7'd25;
      end
      j        = 5'(idx - base);
      c.colour = colour_e'(col);
      c.value  = value_e'(4'((j + 5'd1) >> 1));
    end else begin
      // 100 and 104 are multiples of four, so the low bits give the colour.
      c.colour = colour_e'(idx[1:0]);
      c.value  = (idx < 7'd104) ? WILD : WILD4;
    end
    return c;
  endfunction

  function automatic logic [15:0] mask_upto_msb(input logic [15:0] x);
    logic [15:0] m;
    m = x;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m;
  endfunction

endpackage

// File: rtl/uno_lfsr16.sv
// 16-bit Galois LFSR used as the shuffle random source.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (resets to LFSR_SEED)
//   i_load, i_seed : load a new seed; a zero seed is replaced by LFSR_SEED
//   i_step         : advance one state (ignored while loading)
//   o_q            : current state
module uno_lfsr16
  import uno_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  output logic [15:0] o_q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_load) begin
      // An all-zero state would lock the LFSR up forever.
      lfsr_d = (i_seed == 16'h0000) ? LFSR_SEED : i_seed;
    end else if (i_step) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign o_q = lfsr_q;

endmodule

// File: rtl/uno_card_pile.sv
// UNO draw/discard pile engine. One card array holds both piles: the draw
// pile grows up from index 0, the discard pile grows down from DEPTH-1.
// Supports multi-card draw bursts, automatic recycle + reshuffle of the
// discard pile when the draw pile runs dry, and a seedable shuffle.
// Ports:
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   i_start, i_seed             : rebuild + shuffle the deck (IDLE only)
//   i_draw_valid/num, o_draw_ready : burst draw request handshake
//   o_card_valid, o_card, o_draw_last : drawn card stream
//   i_insert_valid/card, o_insert_ready : discard a card
//   o_draw_cnt, o_disc_cnt      : pile sizes
//   o_busy                      : engine not idle
//   o_err                       : starved draw, insert overflow or bad burst size
module uno_card_pile
  import uno_pkg::*;
#(
  parameter int DEPTH    = 108,
  parameter int CARD_W   = 6,
  parameter int MAX_DRAW = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [15:0]                   i_seed,
  input  logic                          i_draw_valid,
  input  logic [$clog2(MAX_DRAW+1)-1:0] i_draw_num,
  output logic                          o_draw_ready,
  output logic                          o_card_valid,
  output logic [CARD_W-1:0]             o_card,
  output logic                          o_draw_last,
  input  logic                          i_insert_valid,
  input  logic [CARD_W-1:0]             i_insert_card,
  output logic                          o_insert_ready,
  output logic [$clog2(DEPTH+1)-1:0]    o_draw_cnt,
  output logic [$clog2(DEPTH+1)-1:0]    o_disc_cnt,
  output logic                          o_busy,
  output logic                          o_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NUM_W = $clog2(MAX_DRAW + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TOP_C   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(DEPTH - 1);

  logic [CARD_W-1:0] mem_q [DEPTH];
  logic [CARD_W-1:0] kept_q, kept_d;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [6:0]        card_idx_q, card_idx_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [NUM_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  draw_cnt_q, draw_cnt_d;
  logic [CNT_W-1:0]  disc_cnt_q, disc_cnt_d;
  logic              shuf_pend_q, shuf_pend_d;
  logic              resume_q, resume_d;
  logic              busy_q, busy_d;

  logic              we_a, we_b;
  logic [IDX_W-1:0]  wa_a, wa_b;
  logic [CARD_W-1:0] wd_a, wd_b;

  logic              lfsr_load, lfsr_step;
  logic [15:0]       lfsr_q;

  card_t             init_card;
  logic [CNT_W-1:0]  rc_n;
  logic [15:0]       r16;

  uno_lfsr16 u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (lfsr_load),
    .i_seed  (i_seed),
    .i_step  (lfsr_step),
    .o_q     (lfsr_q)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    card_idx_d   = card_idx_q;
    k_d          = k_q;
    rem_d        = rem_q;
    draw_cnt_d   = draw_cnt_q;
    disc_cnt_d   = disc_cnt_q;
    shuf_pend_d  = shuf_pend_q;
    resume_d     = resume_q;
    kept_d       = kept_q;
    we_a         = 1'b0;
    wa_a         = '0;
    wd_a         = '0;
    we_b         = 1'b0;
    wa_b         = '0;
    wd_b         = '0;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
    o_draw_ready   = 1'b0;
    o_insert_ready = 1'b0;
    o_card_valid   = 1'b0;
    o_card         = '0;
    o_draw_last    = 1'b0;
    o_err          = 1'b0;
    init_card    = uno_card_at(card_idx_q);
    rc_n         = disc_cnt_q - ONE_C;
    r16          = lfsr_q & mask_upto_msb(16'(k_q));

    case (state_q)
      ST_INIT: begin
        we_a       = 1'b1;
        wa_a       = idx_q;
        wd_a       = CARD_W'(init_card);
        card_idx_d = (card_idx_q == 7'd107) ? 7'd0 : card_idx_q + 7'd1;
        if (idx_q == LAST_I) begin
          idx_d      = '0;
          card_idx_d = 7'd0;
          draw_cnt_d = DEPTH_C;
          disc_cnt_d = '0;
          if (shuf_pend_q) begin
            shuf_pend_d = 1'b0;
            resume_d    = 1'b0;
            k_d         = LAST_I;
            state_d     = ST_SHUFFLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_IDLE: begin
        o_draw_ready   = 1'b1;
        o_insert_ready = 1'b1;
        if (i_start) begin
          // Everything, including cards out on the table, is rebuilt.
          lfsr_load   = 1'b1;
          idx_d       = '0;
          card_idx_d  = 7'd0;
          draw_cnt_d  = '0;
          disc_cnt_d  = '0;
          shuf_pend_d = 1'b1;
          state_d     = ST_INIT;
        end else begin
          if (i_insert_valid) begin
            if (draw_cnt_q + disc_cnt_q == DEPTH_C) begin
              o_err = 1'b1;
            end else begin
              we_b       = 1'b1;
              wa_b       = IDX_W'(TOP_C - disc_cnt_q);
              wd_b       = i_insert_card;
              disc_cnt_d = disc_cnt_q + ONE_C;
            end
          end
          if (i_draw_valid) begin
            if (i_draw_num == '0 || i_draw_num > NUM_W'(MAX_DRAW)) begin
              o_err = 1'b1;
            end else begin
              rem_d   = i_draw_num;
              state_d = ST_DRAW;
            end
          end
        end
      end

      ST_DRAW: begin
        if (draw_cnt_q != '0) begin
          o_card_valid = 1'b1;
          o_card       = mem_q[IDX_W'(draw_cnt_q - ONE_C)];
          draw_cnt_d   = draw_cnt_q - ONE_C;
          rem_d        = rem_q - NUM_W'(1);
          if (rem_q == NUM_W'(1)) begin
            o_draw_last = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (disc_cnt_q > ONE_C) begin
          // The face-up card may be overwritten by the compaction copy when
          // the discard pile is large, so hold it aside first.
          kept_d  = mem_q[IDX_W'(DEPTH_C - disc_cnt_q)];
          idx_d   = '0;
          state_d = ST_RECYCLE;
        end else begin
          o_err   = 1'b1;
          rem_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_RECYCLE: begin
        if (CNT_W'(idx_q) < rc_n) begin
          // Ascending copy with source above destination: safe even when the
          // two ranges overlap.
          we_a  = 1'b1;
          wa_a  = idx_q;
          wd_a  = mem_q[IDX_W'(DEPTH_C - rc_n + CNT_W'(idx_q))];
          idx_d = idx_q + IDX_W'(1);
        end else begin
          we_a       = 1'b1;
          wa_a       = LAST_I;
          wd_a       = kept_q;
          draw_cnt_d = rc_n;
          disc_cnt_d = ONE_C;
          k_d        = IDX_W'(rc_n - ONE_C);
          resume_d   = 1'b1;
          idx_d      = '0;
          state_d    = ST_SHUFFLE;
        end
      end

      ST_SHUFFLE: begin
        if (k_q == '0) begin
          resume_d = 1'b0;
          state_d  = resume_q ? ST_DRAW : ST_IDLE;
        end else begin
          lfsr_step = 1'b1;
          // Masked draw is rejected and retried when it exceeds k.
          if (r16 <= 16'(k_q)) begin
            we_a = 1'b1;
            wa_a = k_q;
            wd_a = mem_q[IDX_W'(r16)];
            we_b = 1'b1;
            wa_b = IDX_W'(r16);
            wd_b = mem_q[k_q];
            k_d  = k_q - IDX_W'(1);
          end
        end
      end

      default: state_d = ST_INIT;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      card_idx_q  <= 7'd0;
      k_q         <= '0;
      rem_q       <= '0;
      draw_cnt_q  <= '0;
      disc_cnt_q  <= '0;
      shuf_pend_q <= 1'b0;
      resume_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      card_idx_q  <= card_idx_d;
      k_q         <= k_d;
      rem_q       <= rem_d;
      draw_cnt_q  <= draw_cnt_d;
      disc_cnt_q  <= disc_cnt_d;
      shuf_pend_q <= shuf_pend_d;
      resume_q    <= resume_d;
      busy_q      <= busy_d;
    end
  end

  // Card storage carries no reset: INIT rewrites every entry.
  always_ff @(posedge i_clk) begin
    kept_q <= kept_d;
    if (we_a) mem_q[wa_a] <= wd_a;
    if (we_b) mem_q[wa_b] <= wd_b;
  end

  assign o_draw_cnt = draw_cnt_q;
  assign o_disc_cnt = disc_cnt_q;
  assign o_busy     = busy_q;

endmodule
